// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: one-at-a-time sharing of an SRAM-like bus port between fetch and data requesters.
// Define SRAM_ARB_ROUND_ROBIN_EN to alternate grants under contention instead of data-over-fetch priority.
module sram_port_arbiter #(
  parameter int ADDR_WD = 32,
  parameter int DATA_WD = 32,
  parameter int WAIT_LIMIT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inst_req,
  input  logic [ADDR_WD-1:0]   inst_addr,
  output logic [DATA_WD-1:0]   inst_rdata,
  output logic                 inst_done,
  output logic                 inst_stall,
  input  logic                 data_req,
  input  logic [DATA_WD/8-1:0] data_wen,
  input  logic [ADDR_WD-1:0]   data_addr,
  input  logic [DATA_WD-1:0]   data_wdata,
  output logic [DATA_WD-1:0]   data_rdata,
  output logic                 data_done,
  output logic                 data_stall,
  output logic                 mem_req,
  output logic                 mem_wr,
  output logic [DATA_WD/8-1:0] mem_wstrb,
  output logic [ADDR_WD-1:0]   mem_addr,
  output logic [DATA_WD-1:0]   mem_wdata,
  input  logic                 mem_addr_ok,
  input  logic                 mem_data_ok,
  input  logic [DATA_WD-1:0]   mem_rdata,
  output logic                 bus_err
);
  localparam int CW = $clog2(WAIT_LIMIT + 1);
  typedef enum logic [1:0] {IDLE, ADDR, WAIT, RESP} state_t;
  state_t state;
  logic owner_data;
  logic [CW-1:0] cnt;
  logic grant_data;
  logic timeout;
  logic resp_ok;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
  logic last_data;
  assign grant_data = data_req & (~inst_req | ~last_data);
`else
  assign grant_data = data_req;
`endif
  // the cycle that would push the counter to WAIT_LIMIT is the abort cycle
  assign timeout = cnt == CW'(WAIT_LIMIT - 1);
  assign resp_ok = mem_data_ok & ((state == WAIT) | ((state == ADDR) & mem_addr_ok));
  assign mem_req = state == ADDR;
  assign inst_done = (state == RESP) & ~owner_data;
  assign data_done = (state == RESP) & owner_data;
  assign inst_stall = inst_req & ~inst_done;
  assign data_stall = data_req & ~data_done;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner_data <= 1'b0;
      cnt <= '0;
      mem_wr <= 1'b0;
      mem_wstrb <= '0;
      mem_addr <= '0;
      mem_wdata <= '0;
      inst_rdata <= '0;
      data_rdata <= '0;
      bus_err <= 1'b0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      last_data <= 1'b0;
`endif
    end else begin
      bus_err <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (data_req | inst_req) begin
            owner_data <= grant_data;
            mem_addr <= grant_data ? data_addr : inst_addr;
            mem_wstrb <= grant_data ? data_wen : '0;
            mem_wr <= grant_data & (|data_wen);
            mem_wdata <= grant_data ? data_wdata : '0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            last_data <= grant_data;
`endif
            state <= ADDR;
          end
        end
        ADDR, WAIT: begin
          cnt <= cnt + CW'(1);
          if (resp_ok) begin
            if (owner_data & ~mem_wr) data_rdata <= mem_rdata;
            if (~owner_data) inst_rdata <= mem_rdata;
            state <= RESP;
          end else if (timeout) begin
            bus_err <= 1'b1;
            if (owner_data) data_rdata <= '0;
            else inst_rdata <= '0;
            state <= RESP;
          end else if ((state == ADDR) & mem_addr_ok) begin
            state <= WAIT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: randomized self-checking bench with a latency-programmable bus responder.
module tb_sram_port_arbiter;
  localparam int WL = 8;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic inst_req, inst_done, inst_stall, data_req, data_done, data_stall;
  logic [31:0] inst_addr, inst_rdata, data_addr, data_wdata, data_rdata;
  logic [3:0] data_wen, mem_wstrb;
  logic mem_req, mem_wr, mem_addr_ok, mem_data_ok, bus_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  always #5 clk = ~clk;
  sram_port_arbiter #(.ADDR_WD(32), .DATA_WD(32), .WAIT_LIMIT(WL)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata),
    .inst_done(inst_done), .inst_stall(inst_stall),
    .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_done(data_done),
    .data_stall(data_stall),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata), .bus_err(bus_err)
  );
  typedef struct packed {logic [31:0] addr; logic wr; logic [3:0] strb; logic [31:0] wdata;} bus_t;
  bus_t log_q[$];
  int checks = 0;
  int passed = 0;
  int addr_lat = 0, data_lat = 0, acnt = 0, dcnt = 0;
  bit bus_en = 1'b1, pend = 1'b0;
  logic [31:0] pdata;
  logic [31:0] exp_inst_rd, exp_data_rd;
  bit last_data;
  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    return (a == 32'hBFC0_0000) ? 32'h2408_0001 : ({a[15:0], ~a[31:16]} ^ 32'h1357_9BDF);
  endfunction
  function automatic bus_t pop_entry();
    if (log_q.size() == 0) return '0;
    return log_q.pop_front();
  endfunction
  // bus model: addr_ok after addr_lat cycles of mem_req, data_ok data_lat cycles later
  initial begin
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
      if (pend) begin
        if (dcnt == 0) begin mem_data_ok = 1'b1; mem_rdata = pdata; pend = 1'b0; end
        else dcnt--;
      end else if (bus_en && mem_req) begin
        if (acnt == 0) begin
          mem_addr_ok = 1'b1;
          log_q.push_back({mem_addr, mem_wr, mem_wstrb, mem_wdata});
          pdata = rd_fn(mem_addr);
          acnt = addr_lat;
          if (data_lat == 0) begin mem_data_ok = 1'b1; mem_rdata = pdata; end
          else begin pend = 1'b1; dcnt = data_lat - 1; end
        end else acnt--;
      end
    end
  end
  task automatic set_lat(input int a, input int d);
    addr_lat = a; data_lat = d; acnt = a;
  endtask
  task automatic wait_done(input bit is_data, output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (is_data ? data_done : inst_done) begin n = i; break; end
    end
  endtask
  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({mem_req, mem_wr, inst_done, data_done, bus_err, inst_stall, data_stall} !== 7'b0 ||
        mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_wstrb !== 4'h0 ||
        inst_rdata !== 32'h0 || data_rdata !== 32'h0)
      $display("FAIL reset_outputs got req=%b wr=%b addr=%h irdata=%h drdata=%h want all zero",
               mem_req, mem_wr, mem_addr, inst_rdata, data_rdata);
    else passed++;
    rst = 1'b0;
    exp_inst_rd = '0; exp_data_rd = '0; last_data = 1'b0;
  endtask
  task automatic test_fetch;
    int n;
    bus_t e;
    set_lat(0, 0); log_q.delete();
    inst_addr = 32'hBFC0_0000; inst_req = 1'b1;
    wait_done(1'b0, n);
    inst_req = 1'b0;
    exp_inst_rd = 32'h2408_0001; last_data = 1'b0;
    checks++;
    if (n !== 2) $display("FAIL fetch_latency got %0d want 2", n); else passed++;
    checks++;
    if (inst_rdata !== exp_inst_rd) $display("FAIL fetch_rdata got %h want %h", inst_rdata, exp_inst_rd); else passed++;
    e = pop_entry();
    checks++;
    if (e.addr !== 32'hBFC0_0000 || e.wr !== 1'b0 || e.strb !== 4'h0)
      $display("FAIL fetch_bus got addr=%h wr=%b strb=%b want addr=bfc00000 wr=0 strb=0000", e.addr, e.wr, e.strb);
    else passed++;
    @(negedge clk);
    checks++;
    if (inst_done !== 1'b0) $display("FAIL fetch_done_pulse got %b want 0", inst_done); else passed++;
  endtask
  task automatic test_store;
    int n;
    bus_t e;
    set_lat(0, 3); log_q.delete();
    data_addr = 32'h8000_1000; data_wen = 4'b0011; data_wdata = 32'hDEAD_BEEF; data_req = 1'b1;
    wait_done(1'b1, n);
    data_req = 1'b0; data_wen = 4'h0;
    last_data = 1'b1;
    checks++;
    if (n !== 5) $display("FAIL store_latency got %0d want 5", n); else passed++;
    e = pop_entry();
    checks++;
    if (e.addr !== 32'h8000_1000 || e.wr !== 1'b1 || e.strb !== 4'b0011 || e.wdata !== 32'hDEAD_BEEF)
      $display("FAIL store_bus got addr=%h wr=%b strb=%b wdata=%h want 80001000 1 0011 deadbeef",
               e.addr, e.wr, e.strb, e.wdata);
    else passed++;
    checks++;
    if (data_rdata !== exp_data_rd) $display("FAIL store_rdata got %h want %h", data_rdata, exp_data_rd); else passed++;
    @(negedge clk);
  endtask
  task automatic test_contention;
    int td = -1, ti = -1;
    bit first_data, stall_bad = 1'b0;
    bus_t e0, e1;
    set_lat(1, 1); log_q.delete();
    first_data = RR ? !last_data : 1'b1;
    data_addr = 32'h8000_0040; data_wen = 4'h0; inst_addr = 32'hBFC0_0100;
    data_req = 1'b1; inst_req = 1'b1;
    for (int i = 1; i <= 60 && (td < 0 || ti < 0); i++) begin
      @(negedge clk);
      if (inst_stall !== (inst_req & ~inst_done) || data_stall !== (data_req & ~data_done)) stall_bad = 1'b1;
      if (inst_done && ti < 0) begin ti = i; inst_req = 1'b0; end
      if (data_done && td < 0) begin td = i; data_req = 1'b0; end
    end
    checks++;
    if ((first_data ? td : ti) !== 4 || (first_data ? ti : td) !== 9)
      $display("FAIL contention_order got data_done@%0d inst_done@%0d want first=%s at 4, other at 9",
               td, ti, first_data ? "data" : "inst");
    else passed++;
    checks++;
    if (stall_bad) $display("FAIL contention_stall got stall not req&~done want stall held until done"); else passed++;
    e0 = pop_entry(); e1 = pop_entry();
    checks++;
    if (e0.addr !== (first_data ? 32'h8000_0040 : 32'hBFC0_0100) || e1.addr !== (first_data ? 32'hBFC0_0100 : 32'h8000_0040))
      $display("FAIL contention_bus got %h,%h", e0.addr, e1.addr);
    else passed++;
    exp_data_rd = rd_fn(32'h8000_0040); exp_inst_rd = rd_fn(32'hBFC0_0100);
    last_data = !first_data;
    checks++;
    if (data_rdata !== exp_data_rd || inst_rdata !== exp_inst_rd)
      $display("FAIL contention_rdata got %h,%h want %h,%h", data_rdata, inst_rdata, exp_data_rd, exp_inst_rd);
    else passed++;
    @(negedge clk);
  endtask
  task automatic test_back_to_back;
    int k = 0;
    bit exp_d;
    bus_t e;
    set_lat(0, 0); log_q.delete();
    data_addr = 32'h8000_0100; data_wen = 4'h0; inst_addr = 32'hBFC0_0200;
    data_req = 1'b1; inst_req = 1'b1;
    for (int i = 0; i < 80 && k < 4; i++) begin
      @(negedge clk);
      if (data_done || inst_done) k++;
      data_req = (k < 4) && !data_done;
      inst_req = (k < 4) && !inst_done;
    end
    @(negedge clk);
    checks++;
    if (k !== 4 || log_q.size() !== 4) $display("FAIL b2b_count got dones=%0d grants=%0d want 4", k, log_q.size()); else passed++;
    for (int j = 0; j < 4; j++) begin
      exp_d = RR ? !last_data : 1'b1;
      e = pop_entry();
      checks++;
      if (e.addr !== (exp_d ? 32'h8000_0100 : 32'hBFC0_0200))
        $display("FAIL b2b_grant%0d got addr %h want %s", j, e.addr, exp_d ? "data" : "inst");
      else passed++;
      last_data = exp_d;
      if (exp_d) exp_data_rd = rd_fn(32'h8000_0100); else exp_inst_rd = rd_fn(32'hBFC0_0200);
    end
    checks++;
    if (data_rdata !== exp_data_rd || inst_rdata !== exp_inst_rd)
      $display("FAIL b2b_rdata got %h,%h want %h,%h", data_rdata, inst_rdata, exp_data_rd, exp_inst_rd);
    else passed++;
  endtask
  task automatic test_timeout;
    int n;
    set_lat(0, 0); bus_en = 1'b0;
    data_addr = 32'h8000_0200; data_wen = 4'h0; data_req = 1'b1;
    wait_done(1'b1, n);
    data_req = 1'b0;
    exp_data_rd = '0; last_data = 1'b1;
    checks++;
    if (n !== WL + 1) $display("FAIL timeout_latency got %0d want %0d", n, WL + 1); else passed++;
    checks++;
    if (bus_err !== 1'b1 || data_rdata !== exp_data_rd)
      $display("FAIL timeout_abort got bus_err=%b rdata=%h want 1 and %h", bus_err, data_rdata, exp_data_rd);
    else passed++;
    @(negedge clk);
    checks++;
    if (bus_err !== 1'b0 || mem_req !== 1'b0 || data_done !== 1'b0)
      $display("FAIL timeout_idle got bus_err=%b mem_req=%b done=%b want 0", bus_err, mem_req, data_done);
    else passed++;
    bus_en = 1'b1;
  endtask
  task automatic test_reset_wait;
    int n;
    bit bad = 1'b0;
    set_lat(0, 4); log_q.delete();
    data_addr = 32'h8000_0300; data_wen = 4'h0; data_req = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; data_req = 1'b0;
    exp_inst_rd = '0; exp_data_rd = '0; last_data = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (mem_req !== 1'b0 || data_done !== 1'b0 || inst_done !== 1'b0 || bus_err !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (bad) $display("FAIL rstwait_quiet got activity after reset want mem_req=0 and no done"); else passed++;
    checks++;
    if (data_rdata !== exp_data_rd || inst_rdata !== exp_inst_rd)
      $display("FAIL rstwait_rdata got %h,%h want 0", data_rdata, inst_rdata);
    else passed++;
    set_lat(0, 0); log_q.delete();
    data_addr = 32'h8000_0400; data_req = 1'b1;
    wait_done(1'b1, n);
    data_req = 1'b0;
    exp_data_rd = rd_fn(32'h8000_0400); last_data = 1'b1;
    checks++;
    if (n !== 2 || data_rdata !== exp_data_rd)
      $display("FAIL rstwait_next got lat=%0d rdata=%h want 2 and %h", n, data_rdata, exp_data_rd);
    else passed++;
    @(negedge clk);
  endtask
  task automatic test_random;
    for (int it = 0; it < 24; it++) begin
      int a, d, n;
      bit isd;
      logic [31:0] ad, wd;
      logic [3:0] wen;
      bus_t e;
      a = $urandom_range(0, 2); d = $urandom_range(0, 3); set_lat(a, d);
      isd = 1'($urandom_range(0, 1)); ad = $urandom; wd = $urandom;
      wen = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
      log_q.delete();
      if (isd) begin data_addr = ad; data_wen = wen; data_wdata = wd; data_req = 1'b1; end
      else begin inst_addr = ad; inst_req = 1'b1; end
      wait_done(isd, n);
      data_req = 1'b0; inst_req = 1'b0;
      checks++;
      if (n !== 2 + a + d) $display("FAIL rand%0d_latency got %0d want %0d", it, n, 2 + a + d); else passed++;
      e = pop_entry();
      checks++;
      if (e.addr !== ad || e.wr !== (isd && wen != 4'h0) || e.strb !== (isd ? wen : 4'h0) || (isd && e.wdata !== wd))
        $display("FAIL rand%0d_bus got addr=%h wr=%b strb=%b wdata=%h want %h %b %b %h",
                 it, e.addr, e.wr, e.strb, e.wdata, ad, isd && wen != 4'h0, isd ? wen : 4'h0, wd);
      else passed++;
      if (isd && wen == 4'h0) exp_data_rd = rd_fn(ad);
      if (!isd) exp_inst_rd = rd_fn(ad);
      last_data = isd;
      checks++;
      if (data_rdata !== exp_data_rd || inst_rdata !== exp_inst_rd)
        $display("FAIL rand%0d_rdata got %h,%h want %h,%h", it, data_rdata, inst_rdata, exp_data_rd, exp_inst_rd);
      else passed++;
      @(negedge clk);
      checks++;
      if (data_done !== 1'b0 || inst_done !== 1'b0 || mem_req !== 1'b0)
        $display("FAIL rand%0d_idle got done=%b%b mem_req=%b want 0", it, data_done, inst_done, mem_req);
      else passed++;
    end
  endtask
  initial begin
    inst_req = 1'b0; data_req = 1'b0; inst_addr = '0; data_addr = '0; data_wen = '0; data_wdata = '0;
    test_reset;
    test_fetch;
    test_store;
    test_contention;
    test_back_to_back;
    test_timeout;
    test_reset_wait;
    test_random;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
